// File: rtl/fetch_pkg.sv
// Shared definitions for the fetch/decode stage: instruction field positions,
// opcodes without a destination write, and the fetch FSM state encoding.
package fetch_pkg;

    localparam int COND_MSB   = 31;
    localparam int COND_LSB   = 28;
    localparam int OPC_MSB    = 27;
    localparam int OPC_LSB    = 24;
    localparam int S_BIT      = 23;
    localparam int DEST_MSB   = 22;
    localparam int DEST_LSB   = 19;
    localparam int SRC2_MSB   = 18;
    localparam int SRC2_LSB   = 15;
    localparam int SRC1_MSB   = 14;
    localparam int SRC1_LSB   = 11;
    localparam int SHIFT_MSB  = 10;
    localparam int SHIFT_LSB  = 6;
    localparam int EXTRA_MSB  = 5;
    localparam int EXTRA_LSB  = 3;

    localparam logic [3:0] OP_CMP   = 4'hB;
    localparam logic [3:0] OP_NOP_E = 4'hE;
    localparam logic [3:0] OP_NOP_F = 4'hF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } fetch_state_e;

    function automatic logic no_dest(input logic [3:0] opcode);
        return (opcode == OP_CMP) || (opcode == OP_NOP_E) || (opcode == OP_NOP_F);
    endfunction

endpackage

// File: rtl/fetch_queue.sv
// Prefetch FIFO holding {pc, instruction} pairs; pointers carry an extra wrap
// bit so full and empty are distinguishable when the indices coincide.
module fetch_queue #(
    parameter int W     = 40,
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  logic                       flush_i,
    input  logic [W-1:0]               din_i,
    output logic [W-1:0]               head_o,
    output logic [$clog2(DEPTH):0]     count_o,
    output logic                       full_o
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem_q [DEPTH];
    logic [AW:0]  wr_q;
    logic [AW:0]  rd_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q <= '0;
            rd_q <= '0;
        end else if (flush_i) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            if (push_i) wr_q <= wr_q + 1'b1;
            if (pop_i)  rd_q <= rd_q + 1'b1;
        end
    end

    // When full, a simultaneous push overwrites the slot being popped this cycle.
    always_ff @(posedge clk) begin
        if (push_i) mem_q[wr_q[AW-1:0]] <= din_i;
    end

    assign head_o  = mem_q[rd_q[AW-1:0]];
    assign count_o = wr_q - rd_q;
    assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);

endmodule

// File: rtl/fetch_decode_unit.sv
// Clocked fetch/decode stage: owns the PC, issues imem req/ack fetches into a
// prefetch queue and presents the decoded queue head over valid/ready.
module fetch_decode_unit
    import fetch_pkg::*;
#(
    parameter int              PC_W     = 8,
    parameter int              DEPTH    = 2,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            fetch_hold,
    input  logic            redirect_valid,
    input  logic [PC_W-1:0] redirect_pc,
    output logic            imem_req,
    output logic [PC_W-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [31:0]     imem_rdata,
    output logic            dec_valid,
    input  logic            dec_ready,
    output logic [PC_W-1:0] dec_pc,
    output logic [3:0]      dec_cond,
    output logic [3:0]      dec_opcode,
    output logic            dec_s,
    output logic [3:0]      dec_dest,
    output logic [3:0]      dec_src2,
    output logic [3:0]      dec_src1,
    output logic [4:0]      dec_shift,
    output logic [2:0]      dec_extra,
    output logic [15:0]     dec_imm,
    output logic            dec_reg_we
);

    localparam int W  = PC_W + 32;
    localparam int CW = $clog2(DEPTH) + 1;

    fetch_state_e    state_q;
    logic [PC_W-1:0] fetch_pc_q;
    logic [PC_W-1:0] fetch_pc_d;
    logic [CW-1:0]   count;
    logic            full;
    logic [W-1:0]    head;
    logic            pop;
    logic            push;
    logic            space;
    logic [31:0]     instr;

    assign dec_valid = (count != '0);
    assign pop       = dec_valid & dec_ready;
    assign space     = ~full | pop;
    assign imem_req  = (state_q == RUN) & ~fetch_hold & ~redirect_valid & space;
    assign push      = imem_req & imem_ack;
    assign imem_addr = fetch_pc_q;

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        if (redirect_valid) fetch_pc_d = redirect_pc;
        else if (push)      fetch_pc_d = fetch_pc_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            fetch_pc_q <= RESET_PC;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            case (state_q)
                IDLE:    state_q <= RUN;
                RUN:     state_q <= fetch_hold ? HOLD : RUN;
                HOLD:    state_q <= fetch_hold ? HOLD : RUN;
                default: state_q <= IDLE;
            endcase
        end
    end

    fetch_queue #(
        .W     (W),
        .DEPTH (DEPTH)
    ) u_queue (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push),
        .pop_i   (pop),
        .flush_i (redirect_valid),
        .din_i   ({fetch_pc_q, imem_rdata}),
        .head_o  (head),
        .count_o (count),
        .full_o  (full)
    );

    // Fields are forced to zero while the queue is empty so they never show stale slots.
    assign instr      = dec_valid ? head[31:0] : '0;
    assign dec_pc     = dec_valid ? head[W-1:32] : '0;
    assign dec_cond   = instr[COND_MSB:COND_LSB];
    assign dec_opcode = instr[OPC_MSB:OPC_LSB];
    assign dec_s      = instr[S_BIT];
    assign dec_dest   = instr[DEST_MSB:DEST_LSB];
    assign dec_src2   = instr[SRC2_MSB:SRC2_LSB];
    assign dec_src1   = instr[SRC1_MSB:SRC1_LSB];
    assign dec_shift  = instr[SHIFT_MSB:SHIFT_LSB];
    assign dec_extra  = instr[EXTRA_MSB:EXTRA_LSB];
    assign dec_imm    = instr[SRC2_MSB:EXTRA_LSB];
    assign dec_reg_we = dec_valid & ~no_dest(dec_opcode);

endmodule

// File: tb/tb_fetch_decode_unit.sv
// Scenario bench for fetch_decode_unit with a reference model and a scoreboard
// of expected {pc, word} entries pushed on predicted fetches.
module tb_fetch_decode_unit;

    localparam int PC_W  = 8;
    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        fetch_hold;
    logic        redirect_valid;
    logic [7:0]  redirect_pc;
    logic        imem_req;
    logic [7:0]  imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        dec_valid;
    logic        dec_ready;
    logic [7:0]  dec_pc;
    logic [3:0]  dec_cond, dec_opcode, dec_dest, dec_src2, dec_src1;
    logic        dec_s;
    logic [4:0]  dec_shift;
    logic [2:0]  dec_extra;
    logic [15:0] dec_imm;
    logic        dec_reg_we;

    int errors = 0;
    int checks = 0;
    int mem_mode = 0;

    typedef enum {M_IDLE, M_RUN, M_HOLD} mstate_e;
    mstate_e     st_m;
    logic [7:0]  pc_m;
    logic [39:0] exp_q[$];
    logic        exp_valid;
    logic        exp_req;
    logic [39:0] exp_head;

    always #5 clk = ~clk;

    fetch_decode_unit #(.PC_W(PC_W), .DEPTH(DEPTH), .RESET_PC(8'h00)) dut (
        .clk(clk), .rst_n(rst_n), .fetch_hold(fetch_hold),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
        .imem_rdata(imem_rdata), .dec_valid(dec_valid), .dec_ready(dec_ready),
        .dec_pc(dec_pc), .dec_cond(dec_cond), .dec_opcode(dec_opcode),
        .dec_s(dec_s), .dec_dest(dec_dest), .dec_src2(dec_src2),
        .dec_src1(dec_src1), .dec_shift(dec_shift), .dec_extra(dec_extra),
        .dec_imm(dec_imm), .dec_reg_we(dec_reg_we)
    );

    function automatic logic [31:0] word_of(input logic [7:0] a, input int mode);
        if (mode == 1) begin
            case (a)
                8'h10: return 32'hBE00_0000;
                8'h11: return 32'h0F00_0000;
                8'h12: return 32'h2C7F_FFF8;
                8'h13: return 32'h0B00_0000;
                8'h14: return 32'h0A00_0000;
                default: ;
            endcase
        end
        return 32'h0100_0000 + {24'h0, a};
    endfunction

    function automatic logic we_of(input logic [7:0] a, input int mode);
        if (mode == 1 && (a == 8'h10 || a == 8'h11 || a == 8'h13)) return 1'b0;
        return 1'b1;
    endfunction

    assign imem_rdata = word_of(imem_addr, mem_mode);

    task automatic model_reset();
        exp_q.delete();
        pc_m = 8'h00;
        st_m = M_IDLE;
    endtask

    task automatic predict();
        exp_valid = (exp_q.size() != 0);
        exp_head  = exp_valid ? exp_q[0] : '0;
        exp_req   = (st_m == M_RUN) && !fetch_hold && !redirect_valid &&
                    ((exp_q.size() < DEPTH) || (exp_valid && dec_ready));
    endtask

    task automatic commit();
        if (exp_valid && dec_ready) void'(exp_q.pop_front());
        if (redirect_valid) begin
            exp_q.delete();
            pc_m = redirect_pc;
        end else if (exp_req && imem_ack) begin
            exp_q.push_back({pc_m, word_of(pc_m, mem_mode)});
            pc_m = pc_m + 8'h01;
        end
        case (st_m)
            M_IDLE:  st_m = M_RUN;
            M_RUN:   st_m = fetch_hold ? M_HOLD : M_RUN;
            default: st_m = fetch_hold ? M_HOLD : M_RUN;
        endcase
    endtask

    task automatic do_reset();
        rst_n = 1'b0; fetch_hold = 1'b0; redirect_valid = 1'b0; redirect_pc = 8'h00;
        imem_ack = 1'b0; dec_ready = 1'b0; mem_mode = 0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; fetch_hold = 1'b0; redirect_valid = 1'b0; redirect_pc = 8'h00;
        imem_ack = 1'b1; dec_ready = 1'b1;
        #2;
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL reset_req got=%b exp=0", imem_req); end
        checks++; if (dec_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", dec_valid); end
        checks++; if (imem_addr !== 8'h00) begin errors++; $display("FAIL reset_addr got=%h exp=00", imem_addr); end
        checks++; if ({dec_pc, dec_opcode, dec_imm, dec_reg_we} !== '0) begin
            errors++; $display("FAIL reset_fields got pc=%h op=%h imm=%h we=%b exp=0", dec_pc, dec_opcode, dec_imm, dec_reg_we);
        end
        @(posedge clk); #1 rst_n = 1'b1;
        model_reset();
        @(negedge clk);
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL idle_req got=%b exp=0", imem_req); end
        predict(); commit();
        @(posedge clk); #1;
    endtask

    task automatic test_stream();
        do_reset();
        imem_ack = 1'b1; dec_ready = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk); predict();
            checks++; if (imem_req !== exp_req) begin errors++; $display("FAIL stream_req c=%0d got=%b exp=%b", c, imem_req, exp_req); end
            if (exp_req) begin
                checks++; if (imem_addr !== pc_m) begin errors++; $display("FAIL stream_addr c=%0d got=%h exp=%h", c, imem_addr, pc_m); end
            end
            checks++; if (dec_valid !== exp_valid) begin errors++; $display("FAIL stream_valid c=%0d got=%b exp=%b", c, dec_valid, exp_valid); end
            if (exp_valid) begin
                checks++; if (dec_pc !== exp_head[39:32]) begin errors++; $display("FAIL stream_pc c=%0d got=%h exp=%h", c, dec_pc, exp_head[39:32]); end
                checks++; if (dec_opcode !== 4'h1 || dec_reg_we !== 1'b1) begin
                    errors++; $display("FAIL stream_dec c=%0d got op=%h we=%b exp op=1 we=1", c, dec_opcode, dec_reg_we);
                end
            end
            if (c == 2) begin
                checks++; if (dec_valid !== 1'b1 || dec_pc !== 8'h00) begin errors++; $display("FAIL stream_first c=2 got v=%b pc=%h exp v=1 pc=00", dec_valid, dec_pc); end
            end
            commit();
            @(posedge clk); #1;
        end
    endtask

    task automatic test_backpressure();
        int xfers;
        xfers = 0;
        do_reset();
        imem_ack = 1'b1; dec_ready = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk); predict();
            if (imem_req && imem_ack) xfers++;
            checks++; if (imem_req !== exp_req) begin errors++; $display("FAIL bp_req c=%0d got=%b exp=%b", c, imem_req, exp_req); end
            commit();
            @(posedge clk); #1;
        end
        checks++; if (xfers != 2) begin errors++; $display("FAIL bp_xfers got=%0d exp=2", xfers); end
        dec_ready = 1'b1;
        @(negedge clk); predict();
        checks++; if (imem_req !== 1'b1 || imem_addr !== 8'h02) begin errors++; $display("FAIL bp_refill got req=%b addr=%h exp req=1 addr=02", imem_req, imem_addr); end
        checks++; if (dec_pc !== 8'h00) begin errors++; $display("FAIL bp_pop got=%h exp=00", dec_pc); end
        commit();
        @(posedge clk); #1 dec_ready = 1'b0;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk); predict();
            checks++; if (dec_valid !== 1'b1 || dec_pc !== 8'h01 || imem_req !== 1'b0) begin
                errors++; $display("FAIL bp_full c=%0d got v=%b pc=%h req=%b exp v=1 pc=01 req=0", c, dec_valid, dec_pc, imem_req);
            end
            commit();
            @(posedge clk); #1;
        end
    endtask

    task automatic test_redirect();
        do_reset();
        imem_ack = 1'b1; dec_ready = 1'b0;
        redirect_valid = 1'b1; redirect_pc = 8'h05;
        @(negedge clk); predict(); commit();
        @(posedge clk); #1 redirect_valid = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk); predict();
            checks++; if (imem_req !== exp_req) begin errors++; $display("FAIL rd_fill_req c=%0d got=%b exp=%b", c, imem_req, exp_req); end
            commit();
            @(posedge clk); #1;
        end
        redirect_valid = 1'b1; redirect_pc = 8'h40;
        @(negedge clk); predict();
        checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL rd_req_n got=%b exp=0", imem_req); end
        checks++; if (dec_valid !== 1'b1 || dec_pc !== 8'h05) begin errors++; $display("FAIL rd_head got v=%b pc=%h exp v=1 pc=05", dec_valid, dec_pc); end
        commit();
        @(posedge clk); #1 redirect_valid = 1'b0; dec_ready = 1'b1;
        @(negedge clk); predict();
        checks++; if (dec_valid !== 1'b0) begin errors++; $display("FAIL rd_flush got=%b exp=0", dec_valid); end
        checks++; if (imem_req !== 1'b1 || imem_addr !== 8'h40) begin errors++; $display("FAIL rd_target got req=%b addr=%h exp req=1 addr=40", imem_req, imem_addr); end
        commit();
        @(posedge clk); #1;
        @(negedge clk); predict();
        checks++; if (dec_valid !== 1'b1 || dec_pc !== 8'h40) begin errors++; $display("FAIL rd_first got v=%b pc=%h exp v=1 pc=40", dec_valid, dec_pc); end
        commit();
        @(posedge clk); #1;
    endtask

    task automatic test_decode();
        do_reset();
        mem_mode = 1;
        redirect_valid = 1'b1; redirect_pc = 8'h10;
        @(negedge clk); predict(); commit();
        @(posedge clk); #1 redirect_valid = 1'b0; imem_ack = 1'b1; dec_ready = 1'b1;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk); predict();
            checks++; if (dec_valid !== exp_valid) begin errors++; $display("FAIL dec_valid c=%0d got=%b exp=%b", c, dec_valid, exp_valid); end
            if (exp_valid) begin
                checks++; if (dec_pc !== exp_head[39:32] || dec_opcode !== exp_head[27:24]) begin
                    errors++; $display("FAIL dec_head c=%0d got pc=%h op=%h exp pc=%h op=%h", c, dec_pc, dec_opcode, exp_head[39:32], exp_head[27:24]);
                end
                checks++; if (dec_reg_we !== we_of(exp_head[39:32], 1)) begin
                    errors++; $display("FAIL dec_we pc=%h got=%b exp=%b", exp_head[39:32], dec_reg_we, we_of(exp_head[39:32], 1));
                end
                if (exp_head[39:32] == 8'h10) begin
                    checks++; if (dec_cond !== 4'hB) begin errors++; $display("FAIL dec_cond got=%h exp=b", dec_cond); end
                end
                if (exp_head[39:32] == 8'h12) begin
                    checks++;
                    if ({dec_dest, dec_src2, dec_src1, dec_shift, dec_extra, dec_imm, dec_s} !== {4'hF, 4'hF, 4'hF, 5'h1F, 3'h7, 16'hFFFF, 1'b0}) begin
                        errors++; $display("FAIL dec_fields got d=%h s2=%h s1=%h sh=%h ex=%h imm=%h s=%b exp d=f s2=f s1=f sh=1f ex=7 imm=ffff s=0",
                                           dec_dest, dec_src2, dec_src1, dec_shift, dec_extra, dec_imm, dec_s);
                    end
                end
            end
            commit();
            @(posedge clk); #1;
        end
        mem_mode = 0;
    endtask

    task automatic test_wrap();
        do_reset();
        redirect_valid = 1'b1; redirect_pc = 8'hFF;
        @(negedge clk); predict(); commit();
        @(posedge clk); #1 redirect_valid = 1'b0; imem_ack = 1'b1; dec_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk); predict();
            if (exp_req) begin
                checks++; if (imem_addr !== pc_m) begin errors++; $display("FAIL wrap_addr c=%0d got=%h exp=%h", c, imem_addr, pc_m); end
            end
            if (exp_valid && exp_head[39:32] == 8'hFF) begin
                checks++; if (dec_pc !== 8'hFF || imem_addr !== 8'h00) begin
                    errors++; $display("FAIL wrap_edge got pc=%h addr=%h exp pc=ff addr=00", dec_pc, imem_addr);
                end
            end
            commit();
            @(posedge clk); #1;
        end
    endtask

    task automatic test_hold_reset();
        do_reset();
        imem_ack = 1'b1; dec_ready = 1'b1;
        for (int c = 0; c < 12; c++) begin
            fetch_hold = (c >= 4 && c < 7) || c >= 10;
            dec_ready  = (c < 7);
            #0;
            @(negedge clk); predict();
            checks++; if (imem_req !== exp_req) begin errors++; $display("FAIL hold_req c=%0d got=%b exp=%b", c, imem_req, exp_req); end
            checks++; if (dec_valid !== exp_valid) begin errors++; $display("FAIL hold_valid c=%0d got=%b exp=%b", c, dec_valid, exp_valid); end
            if (fetch_hold) begin
                checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL hold_noreq c=%0d got=%b exp=0", c, imem_req); end
            end
            commit();
            @(posedge clk); #1;
        end
        checks++; if (dec_valid !== 1'b1) begin errors++; $display("FAIL hold_pre_reset got=%b exp=1", dec_valid); end
        rst_n = 1'b0;
        #1;
        checks++; if (dec_valid !== 1'b0 || imem_req !== 1'b0 || imem_addr !== 8'h00) begin
            errors++; $display("FAIL async_reset got v=%b req=%b addr=%h exp v=0 req=0 addr=00", dec_valid, imem_req, imem_addr);
        end
        model_reset();
        fetch_hold = 1'b0; dec_ready = 1'b1;
        @(posedge clk); #1 rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk); predict();
            checks++; if (imem_req !== exp_req) begin errors++; $display("FAIL post_reset_req c=%0d got=%b exp=%b", c, imem_req, exp_req); end
            if (exp_req) begin
                checks++; if (imem_addr !== pc_m) begin errors++; $display("FAIL post_reset_addr c=%0d got=%h exp=%h", c, imem_addr, pc_m); end
            end
            commit();
            @(posedge clk); #1;
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect();
        test_decode();
        test_wrap();
        test_hold_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
